load_align_unit: RTL and testbench

Load-side counterpart of the data memory's partial-word store path. Takes the raw 32-bit word read from data memory in the MEM stage and produces the aligned, extended register write-back value for lw/lb/lbu/lh/lhu/lwl/lwr. The value is registered into the MEM/WB boundary. It also detects misaligned loads and records the first faulting address. Sits between DataMemory's ReadData and the WB-stage register file write port.

---
 rtl/load_align_unit_pkg.sv | 21 ++
 rtl/load_align_unit_extract.sv | 63 ++++++
 rtl/load_align_unit.sv | 83 ++++++++
 tb/tb_load_align_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_align_unit_pkg.sv
// Shared load-path types: load_mode encodings and the MEM/WB write-back bundle.
package load_align_unit_pkg;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;
  localparam logic [2:0] LD_LWL = 3'b101;
  localparam logic [2:0] LD_LWR = 3'b110;
  localparam logic [2:0] LD_RSV = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  dst;
  } wb_t;

  localparam wb_t WB_BUBBLE = '{valid: 1'b0, data: 32'd0, dst: 5'd0};

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational byte/halfword/word extraction and misalignment detect.
// lwl/lwr merge exists only when UNALIGNED_LOAD_EN is defined.
module load_extract
  import load_align_unit_pkg::*;
(
  input  logic [2:0]  load_mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_data,
  input  logic [31:0] rt_old,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw_data[{addr_lo, 3'b000} +: 8];
  assign half_sel = raw_data[{addr_lo[1], 4'b0000} +: 16];

`ifdef UNALIGNED_LOAD_EN
  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  // lwl shifts the low bytes up; lwr shifts the high bytes down.
  assign lwl_sh  = {~addr_lo, 3'b000};
  assign lwr_sh  = {addr_lo, 3'b000};
  assign lwl_val = (raw_data << lwl_sh)
                 | (rt_old & ~(32'hFFFF_FFFF << lwl_sh));
  assign lwr_val = (raw_data >> lwr_sh)
                 | (rt_old & ~(32'hFFFF_FFFF >> lwr_sh));
`else
  logic unused_rt;
  assign unused_rt = ^rt_old;
`endif

  always_comb begin
    data       = raw_data;
    misaligned = 1'b0;
    unique case (load_mode)
      LD_LBU: data = {24'd0, byte_sel};
      LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_LHU: begin
        data       = {16'd0, half_sel};
        misaligned = addr_lo[0];
      end
      LD_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
`ifdef UNALIGNED_LOAD_EN
      LD_LWL: data = lwl_val;
      LD_LWR: data = lwr_val;
      LD_LW, LD_RSV: misaligned = |addr_lo;
`else
      LD_LW, LD_LWL, LD_LWR, LD_RSV: misaligned = |addr_lo;
`endif
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// MEM/WB load alignment register with stall/flush and a sticky misalign record.
// Optional lwl/lwr support is selected by UNALIGNED_LOAD_EN.
module load_align_unit
  import load_align_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [2:0]  load_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] raw_data,
  input  logic [31:0] rt_old,
  input  logic [4:0]  dst_reg,
  input  logic        stall,
  input  logic        flush,
  input  logic        err_clr,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dst,
  output logic        err_flag,
  output logic [31:0] err_addr
);

  wb_t         wb_q, wb_d;
  logic        err_flag_q, err_flag_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] ld_data;
  logic        ld_mis;
  logic        new_err;

  load_extract u_extract (
    .load_mode  (load_mode),
    .addr_lo    (mem_addr[1:0]),
    .raw_data   (raw_data),
    .rt_old     (rt_old),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  // Only a load that actually advances into WB may record an error.
  assign new_err = mem_valid & ld_mis & ~flush & ~stall;

  always_comb begin
    wb_d       = wb_q;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    if (flush) begin
      wb_d = WB_BUBBLE;
    end else if (!stall) begin
      if (mem_valid && !ld_mis) begin
        wb_d = '{valid: 1'b1, data: ld_data, dst: dst_reg};
      end else begin
        wb_d = WB_BUBBLE;
      end
    end
    if (new_err && (err_clr || !err_flag_q)) begin
      err_flag_d = 1'b1;
      err_addr_d = mem_addr;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
      err_addr_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q       <= WB_BUBBLE;
      err_flag_q <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      wb_q       <= wb_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign wb_valid = wb_q.valid;
  assign wb_data  = wb_q.data;
  assign wb_dst   = wb_q.dst;
  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: vector table, corner sequences, random vs model.
// Expectations for lwl/lwr follow UNALIGNED_LOAD_EN.
module tb_load_align_unit;
  import load_align_unit_pkg::*;

`ifdef UNALIGNED_LOAD_EN
  localparam bit UAL = 1'b1;
`else
  localparam bit UAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, mem_valid, stall, flush, err_clr;
  logic [2:0]  load_mode;
  logic [31:0] mem_addr, raw_data, rt_old;
  logic [4:0]  dst_reg;
  logic        wb_valid, err_flag;
  logic [31:0] wb_data, err_addr;
  logic [4:0]  wb_dst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_align_unit dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid),
    .load_mode(load_mode), .mem_addr(mem_addr),
    .raw_data(raw_data), .rt_old(rt_old), .dst_reg(dst_reg),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst),
    .err_flag(err_flag), .err_addr(err_addr)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] raw;
    logic [31:0] rt;
    logic [4:0]  dst;
    logic        ev;
    logic [31:0] ed;
    logic [4:0]  edst;
  } vec_t;

  vec_t tv[10];

  function automatic vec_t mk(
    input logic [2:0] m, input logic [31:0] a,
    input logic [31:0] r, input logic [31:0] t,
    input logic [4:0] d, input logic ev,
    input logic [31:0] ed, input logic [4:0] edst);
    vec_t v;
    v.mode = m; v.addr = a; v.raw = r; v.rt = t;
    v.dst = d; v.ev = ev; v.ed = ed; v.edst = edst;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic mv, input logic [2:0] m,
    input logic [31:0] a, input logic [31:0] r,
    input logic [31:0] t, input logic [4:0] d,
    input logic st, input logic fl, input logic ec);
    mem_valid = mv; load_mode = m; mem_addr = a;
    raw_data = r; rt_old = t; dst_reg = d;
    stall = st; flush = fl; err_clr = ec;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte-level reference: assemble results byte by byte.
  function automatic void ref_load(
    input logic [2:0] m, input logic [31:0] a,
    input logic [31:0] raw, input logic [31:0] rt,
    output logic mis, output logic [31:0] d);
    logic [7:0]  rb[4];
    logic [7:0]  tb8[4];
    logic [7:0]  ob[4];
    logic [15:0] h;
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      rb[i]  = raw[8*i +: 8];
      tb8[i] = rt[8*i +: 8];
    end
    mis = 1'b0;
    d = raw;
    case (m)
      3'd1: d = {24'd0, rb[k]};
      3'd2: d = {{24{rb[k][7]}}, rb[k]};
      3'd3, 3'd4: begin
        h = {rb[(k/2)*2+1], rb[(k/2)*2]};
        d = (m == 3'd3) ? {16'd0, h} : {{16{h[15]}}, h};
        mis = (k % 2) == 1;
      end
      3'd5: begin
        if (UAL) begin
          for (int j = 0; j < 4; j++)
            ob[j] = (j >= 3-k) ? rb[j-(3-k)] : tb8[j];
          d = {ob[3], ob[2], ob[1], ob[0]};
        end else mis = (k != 0);
      end
      3'd6: begin
        if (UAL) begin
          for (int j = 0; j < 4; j++)
            ob[j] = (j < 4-k) ? rb[j+k] : tb8[j];
          d = {ob[3], ob[2], ob[1], ob[0]};
        end else mis = (k != 0);
      end
      default: mis = (k != 0);
    endcase
  endfunction

  logic        m_valid, m_flag;
  logic [31:0] m_data, m_addr;
  logic [4:0]  m_dst;

  initial begin
    logic        mis;
    logic [31:0] d;
    logic        nerr;

    tv[0] = mk(LD_LB,  32'h103, 32'h80FF_1234, 0, 5,
               1, 32'hFFFF_FF80, 5);
    tv[1] = mk(LD_LBU, 32'h103, 32'h80FF_1234, 0, 5,
               1, 32'h0000_0080, 5);
    tv[2] = mk(LD_LH,  32'h102, 32'h8001_7FFF, 0, 6,
               1, 32'hFFFF_8001, 6);
    tv[3] = mk(LD_LHU, 32'h100, 32'h8001_7FFF, 0, 6,
               1, 32'h0000_7FFF, 6);
    tv[4] = mk(LD_LW,  32'h200, 32'hDEAD_BEEF, 0, 0,
               1, 32'hDEAD_BEEF, 0);
    tv[5] = mk(LD_LB,  32'h101, 32'h0000_7F00, 0, 31,
               1, 32'h0000_007F, 31);
    if (UAL) begin
      tv[6] = mk(LD_LWL, 32'h101, 32'hAABB_CCDD, 32'h1122_3344,
                 4, 1, 32'hCCDD_3344, 4);
      tv[7] = mk(LD_LWR, 32'h102, 32'hAABB_CCDD, 32'h1122_3344,
                 4, 1, 32'h1122_AABB, 4);
    end else begin
      tv[6] = mk(LD_LWL, 32'h101, 32'hAABB_CCDD, 32'h1122_3344,
                 4, 0, 0, 0);
      tv[7] = mk(LD_LWR, 32'h102, 32'hAABB_CCDD, 32'h1122_3344,
                 4, 0, 0, 0);
    end
    tv[8] = mk(LD_RSV, 32'h104, 32'h1234_5678, 0, 8,
               1, 32'h1234_5678, 8);
    tv[9] = mk(LD_LHU, 32'h103, 32'h1234_5678, 0, 8,
               0, 0, 0);

    reset = 1'b1;
    drive(0, LD_LW, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(wb_valid), 0);
    chk("rst_data", wb_data, 0);
    chk("rst_dst", 32'(wb_dst), 0);
    chk("rst_flag", 32'(err_flag), 0);
    chk("rst_addr", err_addr, 0);

    for (int i = 0; i < 10; i++) begin
      drive(1, tv[i].mode, tv[i].addr, tv[i].raw,
            tv[i].rt, tv[i].dst, 0, 0, 0);
      tick();
      chk($sformatf("tv%0d_valid", i), 32'(wb_valid), 32'(tv[i].ev));
      chk($sformatf("tv%0d_data", i), wb_data, tv[i].ed);
      chk($sformatf("tv%0d_dst", i), 32'(wb_dst), 32'(tv[i].edst));
    end

    // lwl k=1 error behaviour depends on the build
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1, LD_LWL, 32'h101, 32'hAABB_CCDD, 32'h1122_3344,
          4, 0, 0, 0);
    tick();
    chk("lwl_errflag", 32'(err_flag), UAL ? 0 : 1);

    // sticky error record
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1, LD_LW, 32'h106, 32'h5555_AAAA, 0, 9, 0, 0, 0);
    tick();
    chk("mis1_valid", 32'(wb_valid), 0);
    chk("mis1_data", wb_data, 0);
    chk("mis1_dst", 32'(wb_dst), 0);
    chk("mis1_flag", 32'(err_flag), 1);
    chk("mis1_addr", err_addr, 32'h106);
    drive(1, LD_LW, 32'h10A, 32'h5555_AAAA, 0, 9, 0, 0, 0);
    tick();
    chk("mis2_addr", err_addr, 32'h106);
    drive(1, LD_LH, 32'h201, 32'h5555_AAAA, 0, 9, 0, 0, 1);
    tick();
    chk("clrmis_flag", 32'(err_flag), 1);
    chk("clrmis_addr", err_addr, 32'h201);
    drive(0, LD_LW, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("clr_flag", 32'(err_flag), 0);
    chk("clr_addr", err_addr, 0);

    // stall hold, then flush over stall
    drive(1, LD_LW, 32'h300, 32'hCAFE_F00D, 0, 7, 0, 0, 0);
    tick();
    chk("st0_data", wb_data, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      drive(1, LD_LW, 32'h306, $urandom, 0, 3, 1, 0, 0);
      tick();
      chk($sformatf("st%0d_valid", i+1), 32'(wb_valid), 1);
      chk($sformatf("st%0d_data", i+1), wb_data, 32'hCAFE_F00D);
      chk($sformatf("st%0d_dst", i+1), 32'(wb_dst), 7);
      chk($sformatf("st%0d_flag", i+1), 32'(err_flag), 0);
    end
    drive(1, LD_LW, 32'h30A, 32'h1, 0, 3, 1, 1, 0);
    tick();
    chk("fl_valid", 32'(wb_valid), 0);
    chk("fl_data", wb_data, 0);
    chk("fl_flag", 32'(err_flag), 0);
    drive(1, LD_LW, 32'h308, 32'h77, 0, 3, 0, 0, 0);
    tick();
    chk("post_valid", 32'(wb_valid), 1);
    drive(0, LD_LW, 32'h400, 32'h99, 0, 3, 0, 0, 0);
    tick();
    chk("nomv_valid", 32'(wb_valid), 0);

    // reset while holding a valid result and an error
    drive(1, LD_LW, 32'h50E, 32'h1, 0, 2, 0, 0, 0);
    tick();
    drive(1, LD_LW, 32'h500, 32'h11, 0, 2, 0, 0, 0);
    tick();
    chk("pre_rst_valid", 32'(wb_valid), 1);
    chk("pre_rst_flag", 32'(err_flag), 1);
    drive(1, LD_LW, 32'h504, 32'h22, 0, 2, 1, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_valid", 32'(wb_valid), 0);
    chk("rst2_data", wb_data, 0);
    chk("rst2_dst", 32'(wb_dst), 0);
    chk("rst2_flag", 32'(err_flag), 0);
    chk("rst2_addr", err_addr, 0);

    // random traffic against the model
    m_valid = 0; m_data = 0; m_dst = 0; m_flag = 0; m_addr = 0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, 5'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0);
      ref_load(load_mode, mem_addr, raw_data, rt_old, mis, d);
      if (reset) begin
        m_valid = 0; m_data = 0; m_dst = 0; m_flag = 0; m_addr = 0;
      end else begin
        nerr = mem_valid && mis && !flush && !stall;
        if (nerr && (err_clr || !m_flag)) begin
          m_flag = 1; m_addr = mem_addr;
        end else if (err_clr) begin
          m_flag = 0; m_addr = 0;
        end
        if (flush || (!stall && !(mem_valid && !mis))) begin
          m_valid = 0; m_data = 0; m_dst = 0;
        end else if (!stall) begin
          m_valid = 1; m_data = d; m_dst = dst_reg;
        end
      end
      tick();
      chk($sformatf("rnd%0d_valid", n), 32'(wb_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_data", n), wb_data, m_data);
      chk($sformatf("rnd%0d_dst", n), 32'(wb_dst), 32'(m_dst));
      chk($sformatf("rnd%0d_flag", n), 32'(err_flag), 32'(m_flag));
      chk($sformatf("rnd%0d_addr", n), err_addr, m_addr);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
